// File: rtl/cardinal_nic_pkg.sv
// Shared constants for the cardinal NIC: register map, data width and the
// packet bit that carries the virtual-channel tag.
package cardinal_nic_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned VC_BIT = 63;

  localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

endpackage

// File: rtl/cardinal_nic_buf1.sv
// Single-entry packet buffer with a full flag. A load is accepted only while
// empty; clear drops the full flag but keeps the stale data readable.
import cardinal_nic_pkg::*;

module nic_buf1 (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q,
  output logic              full
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load && !full) begin
      q    <= d;
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/cardinal_nic.sv
// Cardinal NIC: CPU-facing register interface with one input and one output
// packet slot. Define CARDINAL_NIC_POLARITY_EN to gate sends on VC polarity.
import cardinal_nic_pkg::*;

module cardinal_nic (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nicEn,
  input  logic              nicEnWr,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [DATA_W-1:0] net_di,
  output logic              net_so,
  input  logic              net_ro,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_polarity
);

  logic [DATA_W-1:0] in_buf;
  logic [DATA_W-1:0] out_buf;
  logic              in_full;
  logic              out_full;
  logic              cpu_rd;
  logic              cpu_wr_out;
  logic              in_pop;

  assign cpu_rd     = nicEn && !nicEnWr;
  assign cpu_wr_out = nicEn && nicEnWr && (addr == ADDR_OUT_BUF);
  assign in_pop     = cpu_rd && (addr == ADDR_IN_BUF) && in_full;

`ifdef CARDINAL_NIC_POLARITY_EN
  assign net_so = out_full && net_ro && (out_buf[VC_BIT] == net_polarity);
`else
  assign net_so = out_full && net_ro;
`endif

  assign net_ri = !in_full;
  assign net_do = out_buf;

  nic_buf1 u_in_buf (
    .clk   (clk),
    .reset (reset),
    .load  (net_si),
    .clear (in_pop),
    .d     (net_di),
    .q     (in_buf),
    .full  (in_full)
  );

  // Load is ignored while full, so a CPU write colliding with a send is dropped.
  nic_buf1 u_out_buf (
    .clk   (clk),
    .reset (reset),
    .load  (cpu_wr_out),
    .clear (net_so),
    .d     (d_in),
    .q     (out_buf),
    .full  (out_full)
  );

  always_comb begin
    d_out = '0;
    if (cpu_rd) begin
      unique case (addr)
        ADDR_IN_BUF:   d_out = in_buf;
        ADDR_IN_STAT:  d_out = {{(DATA_W-1){1'b0}}, in_full};
        ADDR_OUT_STAT: d_out = {{(DATA_W-1){1'b0}}, out_full};
        default:       d_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cardinal_nic.sv
// Self-checking bench for cardinal_nic: directed scenarios followed by random
// traffic, all checked against a slot-level reference model.
module tb_cardinal_nic;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicEnWr;
  logic        net_si;
  logic        net_ri;
  logic [63:0] net_di;
  logic        net_so;
  logic        net_ro;
  logic [63:0] net_do;
  logic        net_polarity;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: one slot per direction
  logic [63:0] m_in_buf, m_out_buf;
  logic        m_in_full, m_out_full;

  cardinal_nic dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicEnWr      (nicEnWr),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_so();
`ifdef CARDINAL_NIC_POLARITY_EN
    return m_out_full && net_ro && (m_out_buf[63] == net_polarity);
`else
    return m_out_full && net_ro;
`endif
  endfunction

  function automatic logic [63:0] exp_dout();
    if (!nicEn || nicEnWr) return 64'd0;
    case (addr)
      2'd0:    return m_in_buf;
      2'd1:    return {63'd0, m_in_full};
      2'd3:    return {63'd0, m_out_full};
      default: return 64'd0;
    endcase
  endfunction

  task automatic idle();
    nicEn = 1'b0; nicEnWr = 1'b0; addr = 2'd0; d_in = '0; net_si = 1'b0;
  endtask

  task automatic cpu(input logic wr, input logic [1:0] a, input logic [63:0] d);
    nicEn = 1'b1; nicEnWr = wr; addr = a; d_in = d;
  endtask

  // Check outputs against the model, then advance model and DUT one edge.
  task automatic cyc(input string tag);
    logic        sent, popped;
    logic [63:0] n_in_buf, n_out_buf;
    logic        n_in_full, n_out_full;
    #1;
    chk({tag, ".net_so"}, {63'd0, net_so}, {63'd0, exp_so()});
    chk({tag, ".net_ri"}, {63'd0, net_ri}, {63'd0, !m_in_full});
    chk({tag, ".net_do"}, net_do, m_out_buf);
    chk({tag, ".d_out"},  d_out,  exp_dout());
    n_in_buf = m_in_buf; n_out_buf = m_out_buf;
    n_in_full = m_in_full; n_out_full = m_out_full;
    if (!reset) begin
      n_in_buf = '0; n_out_buf = '0; n_in_full = 1'b0; n_out_full = 1'b0;
    end else begin
      sent   = exp_so();
      popped = nicEn && !nicEnWr && addr == 2'd0 && m_in_full;
      if (nicEn && nicEnWr && addr == 2'd2 && !m_out_full) begin
        n_out_buf = d_in; n_out_full = 1'b1;
      end else if (sent) n_out_full = 1'b0;
      if (net_si && !m_in_full) begin
        n_in_buf = net_di; n_in_full = 1'b1;
      end else if (popped) n_in_full = 1'b0;
    end
    @(posedge clk);
    m_in_buf = n_in_buf; m_out_buf = n_out_buf;
    m_in_full = n_in_full; m_out_full = n_out_full;
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
    m_in_buf = '1; m_out_buf = '1; m_in_full = 1'b1; m_out_full = 1'b1;
    @(negedge clk);
    @(posedge clk);
    m_in_buf = '0; m_out_buf = '0; m_in_full = 1'b0; m_out_full = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst.net_ri", {63'd0, net_ri}, 64'd1);
    chk("rst.net_so", {63'd0, net_so}, 64'd0);
    chk("rst.net_do", net_do, 64'd0);
    chk("rst.d_out",  d_out,  64'd0);

    // write, immediate send
    net_ro = 1'b1; net_polarity = 1'b0;
    cpu(1'b1, 2'd2, 64'd1234); cyc("wr1234");
    idle(); #1;
    chk("send.net_so", {63'd0, net_so}, 64'd1);
    chk("send.net_do", net_do, 64'd1234);
    cyc("send");
    cpu(1'b0, 2'd3, '0); #1;
    chk("after_send.out_stat", d_out, 64'd0);
    cyc("after_send");

    // VC polarity hold, dropped write while full
    idle(); cpu(1'b1, 2'd2, {1'b1, 63'd0}); cyc("wr_vc1");
    cpu(1'b1, 2'd2, 64'd3333); cyc("wr_held");
    idle(); net_polarity = 1'b1; cyc("pol1");
    net_polarity = 1'b0; cyc("pol_idle");
    cpu(1'b0, 2'd3, '0); cyc("pol_stat");

    // writes to non-writable registers
    cpu(1'b1, 2'd0, 64'd5555); cyc("wr_addr0");
    cpu(1'b1, 2'd1, 64'd5555); cyc("wr_addr1");
    cpu(1'b1, 2'd3, 64'd5555); cyc("wr_addr3");
    cpu(1'b0, 2'd3, '0); #1;
    chk("ign.out_stat", d_out, 64'd0);
    cyc("ign_out_stat");
    cpu(1'b0, 2'd1, '0); cyc("ign_in_stat");

    // receive path
    idle(); net_si = 1'b1; net_di = 64'd1314; cyc("rx");
    net_si = 1'b0; #1;
    chk("rx.net_ri", {63'd0, net_ri}, 64'd0);
    net_si = 1'b1; net_di = 64'd9999; cyc("rx_blocked");
    net_si = 1'b0;
    cpu(1'b0, 2'd1, '0); #1;
    chk("rx.in_stat", d_out, 64'd1);
    cyc("rx_stat");
    cpu(1'b0, 2'd0, '0); #1;
    chk("rx.in_buf", d_out, 64'd1314);
    cyc("rx_read");
    idle(); #1;
    chk("rx_done.net_ri", {63'd0, net_ri}, 64'd1);
    cpu(1'b0, 2'd0, '0); cyc("rx_stale");
    cpu(1'b0, 2'd2, '0); cyc("rd_addr2");
    cpu(1'b1, 2'd0, '0); cyc("wr_gate_dout");

    // router back-pressure
    idle(); net_ro = 1'b0; cpu(1'b1, 2'd2, 64'd77); cyc("bp_wr");
    idle(); cyc("bp_hold0");
    #1; chk("bp.net_do", net_do, 64'd77);
    cyc("bp_hold1");
    net_ro = 1'b1; cyc("bp_release");
    cyc("bp_after");

    // reset with both slots full
    net_ro = 1'b0;
    cpu(1'b1, 2'd2, 64'd99); net_si = 1'b1; net_di = 64'd42; cyc("fill");
    idle(); net_ro = 1'b1; net_polarity = 1'b0;
    reset = 1'b0; cyc("mid_reset");
    reset = 1'b1; net_ro = 1'b0; #1;
    chk("rst2.net_ri", {63'd0, net_ri}, 64'd1);
    chk("rst2.net_so", {63'd0, net_so}, 64'd0);
    chk("rst2.net_do", net_do, 64'd0);
    cpu(1'b0, 2'd1, '0); cyc("rst2_in_stat");
    cpu(1'b0, 2'd3, '0); cyc("rst2_out_stat");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(31) != 0);
      nicEn        = $urandom_range(1);
      nicEnWr      = $urandom_range(1);
      addr         = 2'($urandom_range(3));
      d_in         = {$urandom, $urandom};
      net_si       = $urandom_range(1);
      net_di       = {$urandom, $urandom};
      net_ro       = $urandom_range(1);
      net_polarity = $urandom_range(1);
      cyc("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
